// File: rtl/hc595_pkg.sv
// Shared types and constants for the hc595 chain controller.
package hc595_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    CLEAR
  } state_t;

  localparam int HC595_WIDTH = 8;

  function automatic int chain_width(input int n_chips);
    return HC595_WIDTH * n_chips;
  endfunction

endpackage

// File: rtl/hc595_phase_timer.sv
// Half-phase timer: phase_end is high on the last clk of every CLK_DIV-cycle phase.
// Held in reload while restart is high so the first phase after restart is full length.
module hc595_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign phase_end = (cnt == '0);

endmodule

// File: rtl/hc595_ctrl.sv
// Serialises a parallel word into a daisy chain of hc595 devices, latches it with rclk,
// and offers a clear sequence plus registered output enable. All pins are registered.
module hc595_ctrl
  import hc595_pkg::*;
#(
  parameter int N_CHIPS   = 1,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*N_CHIPS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 clear_i,
  input  logic                 oe_en_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 ser,
  output logic                 srclk,
  output logic                 rclk,
  output logic                 srclr_n,
  output logic                 oe_n
);

  localparam int W  = chain_width(N_CHIPS);
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  state_t         state;
  logic [W-1:0]   sreg;
  logic [W-1:0]   sreg_nxt;
  logic [BW-1:0]  bitcnt;
  logic           clr_phase;
  logic           phase_end;

  function automatic logic lead_bit(input logic [W-1:0] v);
    return (MSB_FIRST != 0) ? v[W-1] : v[0];
  endfunction

  always_comb begin
    sreg_nxt = (MSB_FIRST != 0) ? {sreg[W-2:0], 1'b0} : {1'b0, sreg[W-1:1]};
  end

  hc595_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .restart   (state == IDLE),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_n <= 1'b1;
    end else begin
      oe_n <= ~oe_en_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      bitcnt    <= '0;
      clr_phase <= 1'b0;
      ser       <= 1'b0;
      srclk     <= 1'b0;
      rclk      <= 1'b0;
      srclr_n   <= 1'b1;
      done_o    <= 1'b0;
      ready_o   <= 1'b1;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          ser <= 1'b0;
          // Clear wins over a simultaneous load; the load stays pending.
          if (clear_i) begin
            state     <= CLEAR;
            clr_phase <= 1'b0;
            srclr_n   <= 1'b0;
            ready_o   <= 1'b0;
          end else if (valid_i) begin
            state   <= SHIFT_LO;
            sreg    <= data_i;
            bitcnt  <= BW'(W - 1);
            ser     <= lead_bit(data_i);
            ready_o <= 1'b0;
          end
        end
        SHIFT_LO: begin
          if (phase_end) begin
            srclk <= 1'b1;
            state <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            srclk <= 1'b0;
            if (bitcnt == '0) begin
              rclk  <= 1'b1;
              state <= LATCH;
            end else begin
              bitcnt <= bitcnt - 1'b1;
              sreg   <= sreg_nxt;
              ser    <= lead_bit(sreg_nxt);
              state  <= SHIFT_LO;
            end
          end
        end
        LATCH: begin
          if (phase_end) begin
            rclk    <= 1'b0;
            ser     <= 1'b0;
            done_o  <= 1'b1;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        CLEAR: begin
          if (phase_end) begin
            if (!clr_phase) begin
              srclr_n   <= 1'b1;
              rclk      <= 1'b1;
              clr_phase <= 1'b1;
            end else begin
              rclk    <= 1'b0;
              done_o  <= 1'b1;
              ready_o <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = ~ready_o;

endmodule

// File: tb/tb_hc595_ctrl.sv
// Bench for hc595_ctrl: a 1-chip and a 2-chip instance, each driving a behavioural hc595 chain.
module tb_hc595_ctrl;

  localparam int CLK_DIV = 2;
  localparam int LAT1 = (16 * 1 + 1) * CLK_DIV;
  localparam int LAT2 = (16 * 2 + 1) * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 1-chip instance
  logic [7:0] data1 = '0;
  logic valid1 = 0, clear1 = 0, oe_en1 = 0;
  logic ready1, busy1, done1, ser1, srclk1, rclk1, srclr_n1, oe_n1;

  // 2-chip instance
  logic [15:0] data2 = '0;
  logic valid2 = 0, clear2 = 0, oe_en2 = 0;
  logic ready2, busy2, done2, ser2, srclk2, rclk2, srclr_n2, oe_n2;

  hc595_ctrl #(.N_CHIPS(1), .CLK_DIV(CLK_DIV), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .data_i(data1), .valid_i(valid1), .ready_o(ready1),
    .clear_i(clear1), .oe_en_i(oe_en1), .busy_o(busy1), .done_o(done1),
    .ser(ser1), .srclk(srclk1), .rclk(rclk1), .srclr_n(srclr_n1), .oe_n(oe_n1)
  );

  hc595_ctrl #(.N_CHIPS(2), .CLK_DIV(CLK_DIV), .MSB_FIRST(1)) dut2 (
    .clk(clk), .rst(rst), .data_i(data2), .valid_i(valid2), .ready_o(ready2),
    .clear_i(clear2), .oe_en_i(oe_en2), .busy_o(busy2), .done_o(done2),
    .ser(ser2), .srclk(srclk2), .rclk(rclk2), .srclr_n(srclr_n2), .oe_n(oe_n2)
  );

  // Behavioural hc595 chains: shift on srclk rise, async clear, copy on rclk rise.
  logic [7:0]  ch1 = '0, st1 = '0;
  logic [15:0] ch2 = '0, st2 = '0;
  logic [7:0]  q1;
  logic [15:0] q2;

  always @(posedge srclk1 or negedge srclr_n1)
    if (!srclr_n1) ch1 <= '0; else ch1 <= {ch1[6:0], ser1};
  always @(posedge rclk1) st1 <= ch1;
  always @(posedge srclk2 or negedge srclr_n2)
    if (!srclr_n2) ch2 <= '0; else ch2 <= {ch2[14:0], ser2};
  always @(posedge rclk2) st2 <= ch2;

  assign q1 = oe_n1 ? 8'h00 : st1;
  assign q2 = oe_n2 ? 16'h0000 : st2;

  // Pin activity counters for the 1-chip instance, sampled mid-cycle.
  logic p_srclk1 = 0, p_rclk1 = 0, p_ser1 = 0;
  int srise1 = 0, rrise1 = 0, clrlow1 = 0, viol1 = 0, srise2 = 0;
  logic p_srclk2 = 0;

  always @(negedge clk) begin
    if (srclk1 && !p_srclk1) begin
      srise1++;
      if (ser1 !== p_ser1) viol1++;
    end
    if (rclk1 && !p_rclk1) rrise1++;
    if (!srclr_n1) clrlow1++;
    if (srclk2 && !p_srclk2) srise2++;
    p_srclk1 = srclk1;
    p_rclk1  = rclk1;
    p_ser1   = ser1;
    p_srclk2 = srclk2;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready1();
    int g = 0;
    while (!ready1 && g < 200) begin tick(); g++; end
  endtask

  task automatic start_load1(input logic [7:0] w);
    wait_ready1();
    data1 = w;
    valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    data1 = 8'($urandom);
  endtask

  task automatic wait_done1(output int lat);
    lat = 0;
    while (!done1 && lat < 400) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({ser1, srclk1, rclk1, srclr_n1, oe_n1, done1, ready1, busy1} !== 8'b0001_1010) begin
      n_fail++;
      $display("FAIL reset_pins1: got %b want 00011010",
               {ser1, srclk1, rclk1, srclr_n1, oe_n1, done1, ready1, busy1});
    end
    n_cmp++;
    if ({ser2, srclk2, rclk2, srclr_n2, oe_n2, done2, ready2, busy2} !== 8'b0001_1010) begin
      n_fail++;
      $display("FAIL reset_pins2: got %b want 00011010",
               {ser2, srclk2, rclk2, srclr_n2, oe_n2, done2, ready2, busy2});
    end
  endtask

  task automatic test_idle();
    int s0, r0;
    bit ok = 1;
    rst = 1'b0;
    oe_en1 = 1'b0;
    s0 = srise1;
    r0 = rrise1;
    repeat (10) begin
      tick();
      if (!ready1 || srclk1 || rclk1 || !srclr_n1 || !oe_n1 || busy1) ok = 0;
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_pins: idle pins left rest state (ok=%0d want 1)", ok);
    end
    n_cmp++;
    if ((srise1 - s0) != 0 || (rrise1 - r0) != 0) begin
      n_fail++;
      $display("FAIL idle_toggles: srclk rises %0d rclk rises %0d want 0 0", srise1 - s0, rrise1 - r0);
    end
  endtask

  task automatic test_single_load();
    int s0, r0, v0, lat;
    oe_en1 = 1'b1;
    s0 = srise1; r0 = rrise1; v0 = viol1;
    start_load1(8'b1001_0110);
    wait_done1(lat);
    n_cmp++;
    if (lat != LAT1) begin
      n_fail++; $display("FAIL load_latency: got %0d want %0d", lat, LAT1);
    end
    n_cmp++;
    if (srise1 - s0 != 8) begin
      n_fail++; $display("FAIL load_srclk_rises: got %0d want 8", srise1 - s0);
    end
    n_cmp++;
    if (rrise1 - r0 != 1) begin
      n_fail++; $display("FAIL load_rclk_pulses: got %0d want 1", rrise1 - r0);
    end
    n_cmp++;
    if (viol1 - v0 != 0) begin
      n_fail++; $display("FAIL load_ser_setup: ser changed on %0d srclk rises, want 0", viol1 - v0);
    end
    n_cmp++;
    if (q1 !== 8'b1001_0110) begin
      n_fail++; $display("FAIL load_q: got %b want 10010110", q1);
    end
    n_cmp++;
    if (ready1 !== 1'b1) begin
      n_fail++; $display("FAIL load_ready_on_done: got %b want 1", ready1);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0, d = 0, bc = 0;
    bit prev_done = 0;
    wait_ready1();
    data1 = 8'b0110_1001;
    valid1 = 1'b1;
    tick();
    data1 = 8'b1111_0000;
    while (d < 2 && k < 300) begin
      bc += int'(busy1);
      if (prev_done) begin
        n_cmp++;
        if (busy1 !== 1'b1) begin
          n_fail++; $display("FAIL b2b_no_gap: busy %b one cycle after done, want 1", busy1);
        end
        valid1 = 1'b0;
      end
      prev_done = done1;
      if (done1) begin
        d++;
        if (d == 1) begin
          n_cmp++;
          if (k != LAT1 || q1 !== 8'b0110_1001 || ready1 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: k=%0d q=%b ready=%b want k=%0d q=01101001 ready=1",
                     k, q1, ready1, LAT1);
          end
        end else begin
          n_cmp++;
          if (k != 2 * LAT1 + 1 || q1 !== 8'b1111_0000) begin
            n_fail++;
            $display("FAIL b2b_second: k=%0d q=%b want k=%0d q=11110000", k, q1, 2 * LAT1 + 1);
          end
        end
      end
      tick();
      k++;
    end
    valid1 = 1'b0;
    n_cmp++;
    if (bc != 2 * LAT1) begin
      n_fail++; $display("FAIL b2b_busy_total: got %0d want %0d", bc, 2 * LAT1);
    end
  endtask

  task automatic test_clear_priority();
    int lat, k, c0, r0;
    start_load1(8'hAA);
    wait_done1(lat);
    n_cmp++;
    if (q1 !== 8'hAA) begin
      n_fail++; $display("FAIL clr_preload_q: got %h want aa", q1);
    end
    wait_ready1();
    c0 = clrlow1; r0 = rrise1;
    clear1 = 1'b1;
    valid1 = 1'b1;
    data1 = 8'h55;
    tick();
    clear1 = 1'b0;
    k = 0;
    while (!done1 && k < 100) begin tick(); k++; end
    n_cmp++;
    if (k != 2 * CLK_DIV) begin
      n_fail++; $display("FAIL clr_latency: got %0d want %0d", k, 2 * CLK_DIV);
    end
    n_cmp++;
    if (clrlow1 - c0 != CLK_DIV) begin
      n_fail++; $display("FAIL clr_srclr_low: got %0d want %0d", clrlow1 - c0, CLK_DIV);
    end
    n_cmp++;
    if (rrise1 - r0 != 1 || q1 !== 8'h00) begin
      n_fail++; $display("FAIL clr_q: rclk pulses %0d q=%h want 1 00", rrise1 - r0, q1);
    end
    tick();
    n_cmp++;
    if (busy1 !== 1'b1) begin
      n_fail++; $display("FAIL clr_pending_accept: busy %b want 1", busy1);
    end
    valid1 = 1'b0;
    wait_done1(lat);
    n_cmp++;
    if (lat != LAT1 || q1 !== 8'h55) begin
      n_fail++; $display("FAIL clr_pending_word: lat=%0d q=%h want %0d 55", lat, q1, LAT1);
    end
  endtask

  task automatic test_random();
    logic [7:0] w;
    int lat, s0;
    for (int i = 0; i < 12; i++) begin
      w = 8'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      s0 = srise1;
      start_load1(w);
      wait_done1(lat);
      n_cmp++;
      if (lat != LAT1 || q1 !== w || srise1 - s0 != 8) begin
        n_fail++;
        $display("FAIL rand_load[%0d]: lat=%0d q=%h rises=%0d want %0d %h 8", i, lat, q1, srise1 - s0, LAT1, w);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat, r0, s0, g;
    start_load1(8'hF0);
    wait_done1(lat);
    n_cmp++;
    if (q1 !== 8'hF0) begin
      n_fail++; $display("FAIL rst_preload_q: got %h want f0", q1);
    end
    r0 = rrise1; s0 = srise1;
    start_load1(8'h0F);
    g = 0;
    while (srise1 - s0 < 3 && g < 200) begin tick(); g++; end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ser1, srclk1, rclk1, srclr_n1, oe_n1, done1, ready1, busy1} !== 8'b0001_1010) begin
      n_fail++;
      $display("FAIL rst_mid_pins: got %b want 00011010",
               {ser1, srclk1, rclk1, srclr_n1, oe_n1, done1, ready1, busy1});
    end
    n_cmp++;
    if (st1 !== 8'hF0 || rrise1 != r0) begin
      n_fail++; $display("FAIL rst_mid_storage: st=%h rclk pulses=%0d want f0 0", st1, rrise1 - r0);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (ready1 !== 1'b1 || q1 !== 8'hF0) begin
      n_fail++; $display("FAIL rst_release: ready=%b q=%h want 1 f0", ready1, q1);
    end
  endtask

  task automatic test_chain_oe();
    logic [15:0] w;
    int lat, s0;
    oe_en2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = (i == 0) ? 16'hA55A : 16'($urandom);
      lat = 0;
      while (!ready2 && lat < 200) begin tick(); lat++; end
      s0 = srise2;
      data2 = w;
      valid2 = 1'b1;
      tick();
      valid2 = 1'b0;
      lat = 0;
      while (!done2 && lat < 400) begin tick(); lat++; end
      n_cmp++;
      if (lat != LAT2 || srise2 - s0 != 16) begin
        n_fail++; $display("FAIL chain_latency[%0d]: lat=%0d rises=%0d want %0d 16", i, lat, srise2 - s0, LAT2);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (q2[8*k +: 8] !== w[8*k +: 8]) begin
          n_fail++; $display("FAIL chain_dev%0d[%0d]: got %h want %h", k, i, q2[8*k +: 8], w[8*k +: 8]);
        end
      end
    end
    oe_en2 = 1'b0;
    n_cmp++;
    if (oe_n2 !== 1'b0) begin
      n_fail++; $display("FAIL oe_latency_early: oe_n=%b want 0 before next edge", oe_n2);
    end
    tick();
    n_cmp++;
    if (oe_n2 !== 1'b1 || q2 !== 16'h0000) begin
      n_fail++; $display("FAIL oe_disable: oe_n=%b q=%h want 1 0000", oe_n2, q2);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_load();
    test_back_to_back();
    test_clear_priority();
    test_random();
    test_reset_mid_shift();
    test_chain_oe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
